fifo_rr_sched: RTL and testbench

//  Round-robin drain scheduler for C_NUM_QUEUES small first-word-fall-through FIFOs feeding one shared output port.
//  - Grants one non-empty queue at a time and pops it with q_rd_en while the downstream accepts words.
//  - Holds the grant for a whole packet (EOP-delimited) or for a bounded burst.
//  - Sits between the per-port input FIFOs and the shared match/forward pipeline.

---
 rtl/fifo_rr_sched_pkg.sv | 12 +
 rtl/fifo_rr_sched_rr_pick.sv | 28 ++
 rtl/fifo_rr_sched.sv | 124 ++++++++++++
 tb/tb_fifo_rr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_sched_pkg.sv
// Shared types and widths for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } sched_state_t;

    localparam int BURST_W = 8;
    localparam int STAT_W  = 32;

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// Rotating-priority encoder: first set req bit after 'last', wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Scan from lowest to highest priority so the nearest request after 'last' wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IW'((int'(last) + k) % N);
            if (req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin drain of C_NUM_QUEUES FWFT FIFOs onto one output port, per packet or per burst.
// Optional per-queue pop counters when FIFO_SCHED_STATS_EN is defined.
module fifo_rr_sched
    import fifo_sched_pkg::*;
#(
    parameter  int C_NUM_QUEUES = 4,
    parameter  int C_WIDTH      = 28,
    parameter  int C_PKT_MODE   = 1,
    parameter  int C_EOP_BIT    = C_WIDTH - 1,
    parameter  int C_MAX_BURST  = 4,
    localparam int QW           = $clog2(C_NUM_QUEUES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_NUM_QUEUES*C_WIDTH-1:0] q_dout,
    input  logic [C_NUM_QUEUES-1:0]         q_empty,
    output logic [C_NUM_QUEUES-1:0]         q_rd_en,
    output logic [C_WIDTH-1:0]              out_data,
    output logic [QW-1:0]                   out_qid,
    output logic                            out_valid,
    input  logic                            out_rdy,
    output logic                            busy,
    input  logic [QW-1:0]                   stat_sel,
    output logic [STAT_W-1:0]               stat_cnt
);

    sched_state_t       state;
    logic [QW-1:0]      grant;
    logic [QW-1:0]      last_grant;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W:0]   burst_nxt;
    logic               pick_any;
    logic [QW-1:0]      pick_idx;
    logic [C_WIDTH-1:0] head;
    logic               head_empty;
    logic               pop;
    logic               done;

    rr_pick #(.N(C_NUM_QUEUES)) u_pick (
        .req  (~q_empty),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Data path is pure muxing off the registered grant: no added latency.
    assign head       = q_dout[grant*C_WIDTH +: C_WIDTH];
    assign head_empty = q_empty[grant];
    assign out_valid  = (state == ST_XFER) && !head_empty;
    assign pop        = out_valid & out_rdy;
    assign out_data   = head;
    assign out_qid    = grant;
    assign busy       = (state == ST_XFER);
    assign burst_nxt  = {1'b0, burst_cnt} + (BURST_W+1)'(1);

    always_comb begin
        q_rd_en        = '0;
        q_rd_en[grant] = pop;
    end

    // Packet mode waits indefinitely on a mid-packet empty; burst mode gives up the grant.
    generate
        if (C_PKT_MODE != 0) begin : g_pkt
            assign done = pop & head[C_EOP_BIT];
        end else begin : g_burst
            assign done = (pop & (burst_nxt == (BURST_W+1)'(C_MAX_BURST))) | head_empty;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= QW'(C_NUM_QUEUES - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (pop)
                        burst_cnt <= burst_nxt[BURST_W-1:0];
                    if (done) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [C_NUM_QUEUES];

    for (genvar i = 0; i < C_NUM_QUEUES; i++) begin : g_stat
        always_ff @(posedge clk) begin
            if (rst)
                stat_q[i] <= '0;
            else if (q_rd_en[i])
                stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stat_cnt <= '0;
        else if (int'(stat_sel) < C_NUM_QUEUES)
            stat_cnt <= stat_q[stat_sel];
        else
            stat_cnt <= '0;
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench: packet-mode instance (port 0) and burst-mode instance (port 1) fed by queue FIFO models.
module tb_fifo_rr_sched;

    localparam int N  = 4;
    localparam int W  = 28;
    localparam int QW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N*W-1:0]   q_dout  [2];
    logic [N-1:0]     q_empty [2];
    logic             rdy     [2];
    logic [QW-1:0]    stat_sel;

    logic [N-1:0]     rd_a, rd_b;
    logic [W-1:0]     data_a, data_b;
    logic [QW-1:0]    qid_a, qid_b;
    logic             valid_a, valid_b, busy_a, busy_b;
    logic [31:0]      stat_a, stat_b;

    logic [W-1:0]     fifo [2*N][$];
    logic [QW+W-1:0]  sb   [2][$];
    int               n_cmp = 0;
    int               n_fail = 0;

    fifo_rr_sched #(.C_NUM_QUEUES(N), .C_WIDTH(W), .C_PKT_MODE(1)) dut (
        .clk(clk), .rst(rst), .q_dout(q_dout[0]), .q_empty(q_empty[0]), .q_rd_en(rd_a),
        .out_data(data_a), .out_qid(qid_a), .out_valid(valid_a), .out_rdy(rdy[0]),
        .busy(busy_a), .stat_sel(stat_sel), .stat_cnt(stat_a)
    );

    fifo_rr_sched #(.C_NUM_QUEUES(N), .C_WIDTH(W), .C_PKT_MODE(0), .C_MAX_BURST(4)) dut_b (
        .clk(clk), .rst(rst), .q_dout(q_dout[1]), .q_empty(q_empty[1]), .q_rd_en(rd_b),
        .out_data(data_b), .out_qid(qid_b), .out_valid(valid_b), .out_rdy(rdy[1]),
        .busy(busy_b), .stat_sel(stat_sel), .stat_cnt(stat_b)
    );

    function automatic logic [W-1:0] wd(input int q, input int j, input bit eop);
        return {eop, 11'h0, 4'(q), 12'(j)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                q_empty[p][i]       = (fifo[p*N+i].size() == 0);
                q_dout[p][i*W +: W] = (fifo[p*N+i].size() != 0) ? fifo[p*N+i][0] : '0;
            end
    endtask

    task automatic load(input int p, input int q, input logic [W-1:0] w);
        fifo[p*N+q].push_back(w);
        refresh();
    endtask

    task automatic expect_pop(input int p, input int q, input logic [W-1:0] w);
        sb[p].push_back({QW'(q), w});
    endtask

    // Score pops just before the edge, advance one clock, update FIFO models, return at negedge.
    task automatic cyc();
        logic [N-1:0]    rd  [2];
        logic [QW+W-1:0] obs [2];
        logic [QW+W-1:0] exp;
        #1;
        rd[0] = rd_a;  obs[0] = {qid_a, data_a};
        rd[1] = rd_b;  obs[1] = {qid_b, data_b};
        for (int p = 0; p < 2; p++) begin
            chk("rd_onehot", 64'($onehot0(rd[p])), 64'd1);
            chk("rd_while_empty", 64'(rd[p] & q_empty[p]), 64'd0);
            if (rd[p] != '0) begin
                exp = (sb[p].size() != 0) ? sb[p].pop_front() : '1;
                chk(p == 0 ? "pop_word_pkt" : "pop_word_burst", 64'(obs[p]), 64'(exp));
                chk("pop_strobe", 64'(rd[p]), 64'(N'(1) << exp[QW+W-1:W]));
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                if (rd[p][i] && fifo[p*N+i].size() != 0)
                    void'(fifo[p*N+i].pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic drain(input int p);
        for (int k = 0; k < 80 && sb[p].size() != 0; k++)
            cyc();
        chk("drain_complete", 64'(sb[p].size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_stat [N];
        exp_stat = '{32'd4, 32'd5, 32'd4, 32'd4};
        rst = 1'b1;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        stat_sel = '0;
        refresh();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_rd_en", 64'(rd_a), 0);
        chk("rst_valid", 64'(valid_a), 0);
        chk("rst_qid", 64'(qid_a), 0);
        chk("rst_stat", 64'(stat_a), 0);
        rst = 1'b0;
        cyc();

        // One 1-word packet in every queue: q0..q3 with a bubble between grants
        for (int i = 0; i < N; i++) begin
            load(0, i, wd(i, 0, 1));
            expect_pop(0, i, wd(i, 0, 1));
        end
        for (int i = 0; i < N; i++) begin
            cyc();
            chk("t1_busy", 64'(busy_a), 1);
            chk("t1_valid", 64'(valid_a), 1);
            chk("t1_qid", 64'(qid_a), 64'(i));
            chk("t1_rd_en", 64'(rd_a), 64'(1 << i));
            cyc();
            chk("t1_bubble", 64'(busy_a), 0);
        end

        // q0 1-word (moves last_grant to 0), then q1 3-word packet, then q2
        load(0, 0, wd(0, 0, 1));  expect_pop(0, 0, wd(0, 0, 1));
        for (int j = 0; j < 3; j++) begin
            load(0, 1, wd(1, j, j == 2));
            expect_pop(0, 1, wd(1, j, j == 2));
        end
        load(0, 2, wd(2, 0, 1));  expect_pop(0, 2, wd(2, 0, 1));
        cyc();
        chk("t2_q0", 64'(qid_a), 0);
        cyc();
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("t2_q1_qid", 64'(qid_a), 1);
            chk("t2_q1_data", 64'(data_a), 64'(wd(1, j, j == 2)));
            chk("t2_q1_rd", 64'(rd_a), 64'h2);
        end
        cyc();
        chk("t2_bubble", 64'(busy_a), 0);
        cyc();
        chk("t2_q2_rd", 64'(rd_a), 64'h4);
        cyc();
        chk("t2_sb", 64'(sb[0].size()), 0);

        // Mid-packet empty on q0 while q1/q2 wait
        load(0, 0, wd(0, 0, 0));  expect_pop(0, 0, wd(0, 0, 0));
        load(0, 1, wd(1, 5, 1));
        load(0, 2, wd(2, 5, 1));
        expect_pop(0, 0, wd(0, 1, 1));
        expect_pop(0, 1, wd(1, 5, 1));
        expect_pop(0, 2, wd(2, 5, 1));
        cyc();
        chk("t3_first", 64'(qid_a), 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3_hold_busy", 64'(busy_a), 1);
            chk("t3_hold_valid", 64'(valid_a), 0);
            chk("t3_hold_rd", 64'(rd_a), 0);
            chk("t3_hold_qid", 64'(qid_a), 0);
        end
        load(0, 0, wd(0, 1, 1));
        #1;
        chk("t3_resume_valid", 64'(valid_a), 1);
        chk("t3_resume_data", 64'(data_a), 64'(wd(0, 1, 1)));
        drain(0);
        cyc();
        chk("t3_idle", 64'(busy_a), 0);

        // out_rdy back-pressure on q3 (last_grant now 2)
        for (int j = 0; j < 3; j++) begin
            load(0, 3, wd(3, j, j == 2));
            expect_pop(0, 3, wd(3, j, j == 2));
        end
        cyc();
        chk("t4_rd_w0", 64'(rd_a), 64'h8);
        rdy[0] = 1'b0;  #1;
        chk("t4_stall_rd", 64'(rd_a), 0);
        cyc();
        chk("t4_stall_data", 64'(data_a), 64'(wd(3, 0, 0)));
        rdy[0] = 1'b1;  #1;
        chk("t4_go_rd", 64'(rd_a), 64'h8);
        cyc();
        chk("t4_w1", 64'(data_a), 64'(wd(3, 1, 0)));
        rdy[0] = 1'b0;  #1;
        chk("t4_stall2_rd", 64'(rd_a), 0);
        cyc();
        chk("t4_stall2_data", 64'(data_a), 64'(wd(3, 1, 0)));
        rdy[0] = 1'b1;
        drain(0);
        cyc();
        chk("t4_idle", 64'(busy_a), 0);

        // Burst mode: 10 words each in q0/q1 -> 4,4,4,4,2,2
        for (int j = 0; j < 10; j++) begin
            load(1, 0, wd(0, j, j[0]));
            load(1, 1, wd(1, j, j[0]));
        end
        for (int b = 0; b < 3; b++)
            for (int q = 0; q < 2; q++)
                for (int j = b*4; j < b*4 + 4 && j < 10; j++)
                    expect_pop(1, q, wd(q, j, j[0]));
        drain(1);
        cyc();
        chk("t5_idle", 64'(busy_b), 0);

        // Reset mid-packet on q2 (last_grant now 3)
        for (int j = 0; j < 3; j++)
            load(0, 2, wd(2, j, j == 2));
        expect_pop(0, 2, wd(2, 0, 0));
        cyc();
        chk("t6_grant", 64'(qid_a), 2);
        cyc();
        chk("t6_mid", 64'(data_a), 64'(wd(2, 1, 0)));
        rdy[0] = 1'b0;
`ifdef FIFO_SCHED_STATS_EN
        for (int s = 0; s < N; s++) begin
            stat_sel = QW'(s);
            cyc();
            chk("t6_stat_count", 64'(stat_a), 64'(exp_stat[s]));
        end
`endif
        rst = 1'b1;
        cyc();
        chk("t6_rst_rd", 64'(rd_a), 0);
        chk("t6_rst_busy", 64'(busy_a), 0);
        chk("t6_rst_valid", 64'(valid_a), 0);
        chk("t6_rst_qid", 64'(qid_a), 0);
        load(0, 0, wd(0, 9, 1));
        expect_pop(0, 0, wd(0, 9, 1));
        expect_pop(0, 2, wd(2, 1, 0));
        expect_pop(0, 2, wd(2, 2, 1));
        for (int s = 0; s < N; s++) begin
            stat_sel = QW'(s);
            cyc();
            chk("t6_stat_zero", 64'(stat_a), 0);
            chk("t6_stat_zero_b", 64'(stat_b), 0);
        end
        rst = 1'b0;
        rdy[0] = 1'b1;
        cyc();
        chk("t6_q0_first", 64'(qid_a), 0);
        chk("t6_q0_valid", 64'(valid_a), 1);
        drain(0);
        cyc();
        chk("t6_idle", 64'(busy_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
